demux_1_4_seq: RTL
==================

DEMUX_1_4_SEQ -- requirements
Module: demux_1_4_seq

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits of the input stream and of each output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_data  input  WIDTH  input stream data word.
REQ-005 Port: in_valid  input  1  in_data carries a word this cycle.
REQ-006 Port: in_ready  output  1  block accepts a word this cycle.
REQ-007 Port: s  input  2  explicit channel select; present only when DEMUX_EXPLICIT_SEL_EN is defined.
REQ-008 Port: out_data  output  4*WIDTH  channel k data in bits [k*WIDTH +: WIDTH], k = 0..3.
REQ-009 Port: out_valid  output  4  bit k set while channel k holds an unconsumed word.
REQ-010 Port: out_ready  input  4  bit k set when the channel k consumer takes its word this cycle.
REQ-011 Port: ptr  output  2  accept counter modulo 4 (the round-robin target channel).
REQ-012 Port: frame_done  output  1  one-cycle pulse after every 4th accepted word.

Function
REQ-013 The target channel t SHALL be ptr (round-robin) by default, or s when DEMUX_EXPLICIT_SEL_EN is defined.
REQ-014 in_ready SHALL be combinational: ~out_valid[t] | out_ready[t]; it does not depend on in_valid.
REQ-015 An accept SHALL occur on a rising edge where in_valid & in_ready = 1.
REQ-016 On accept, the block SHALL set out_data[t] <= in_data and out_valid[t] <= 1, and SHALL update ptr <= ptr + 1, wrapping 3 -> 0.
REQ-017 Latency SHALL be 1 cycle: a word accepted at edge N is visible on channel t with out_valid[t] = 1 after edge N.
REQ-018 Drain: on an edge with out_valid[k] & out_ready[k], the block SHALL clear out_valid[k], unless the same edge accepts a new word into channel k, in which case out_valid[k] stays 1 and the new data is loaded.
REQ-019 out_ready[k] while out_valid[k] = 0 SHALL have no effect.
REQ-020 out_data[k] SHALL hold stable while out_valid[k] = 1 and the word is not consumed; a non-target channel's data and valid SHALL never change because of an accept.
REQ-021 In round-robin mode, a full target channel SHALL stall the whole stream: no skipping to another channel, ptr holds, in_ready = 0.
REQ-022 When no accept occurs, ptr SHALL hold its value.
REQ-023 frame_done SHALL be registered and pulse high for exactly one cycle after the edge whose accept wraps ptr from 3 to 0.
REQ-024 No input word SHALL be lost or duplicated; every accepted word SHALL be presented exactly once on exactly one channel.

Reset
REQ-025 While rst = 1, the block SHALL asynchronously force out_valid = 4'b0000, out_data = 0, ptr = 0 and frame_done = 0.
REQ-026 Because out_valid = 0 during reset, in_ready SHALL be 1 during and immediately after reset.
REQ-027 Reset asserted mid-operation SHALL discard all held words without emitting frame_done; the first accept after reset deassertion goes to channel 0 (round-robin mode).

Configuration
REQ-028 Macro DEMUX_EXPLICIT_SEL_EN: when defined, port s exists and selects t, out-of-order channel use is allowed, and ptr/frame_done count accepts regardless of channel.
REQ-029 When DEMUX_EXPLICIT_SEL_EN is undefined, port s SHALL be absent and t = ptr.

Verification
REQ-030 Scenario 1: reset, out_ready = 4'b1111, feed 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> each word appears one cycle later on channels 0, 1, 2, 3 respectively; ptr reads 1, 2, 3, 0; frame_done pulses once.
REQ-031 Scenario 2: out_ready = 0, feed 4 words -> out_valid = 4'b1111; 5th word sees in_ready = 0 and ptr = 0; raising out_ready[0] accepts it into channel 0 on the same edge, and out_valid[0] stays 1 with the new data.
REQ-032 Scenario 3: channel 1 full with out_ready[1] = 0, ptr = 1 -> in_ready = 0 even though channels 2 and 3 are empty; no data moves until out_ready[1] = 1.
REQ-033 Scenario 4: rst pulsed while out_valid = 4'b0101 and ptr = 2 -> out_valid = 0, out_data = 0, ptr = 0 immediately, with no frame_done pulse.
REQ-034 Scenario 5 (DEMUX_EXPLICIT_SEL_EN): s = 3, 2, 3 with 0xA0, 0xB0, 0xC0 and out_ready = 0 -> channel 3 = 0xA0, channel 2 = 0xB0, and the third word stalls (in_ready = 0) until out_ready[3] = 1.

Source files
------------

// File: rtl/demux_1_4_seq.sv
// ---------------------------------------------------------------------------
// demux_1_4_seq
//
// Sequential 1-to-4 stream demultiplexer with valid/ready handshakes on the
// input and on each of the four output channels. Every accepted input word is
// registered into exactly one output channel and held there until that
// channel's consumer takes it.
//
// The target channel is the accept counter ptr (round-robin). When the macro
// DEMUX_EXPLICIT_SEL_EN is defined, an extra port s chooses the target
// instead, and ptr / frame_done keep counting accepts regardless of channel.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_data     input stream word (WIDTH bits)
//   in_valid    in_data carries a word this cycle
//   in_ready    block can take a word this cycle (combinational)
//   s           explicit channel select (DEMUX_EXPLICIT_SEL_EN only)
//   out_data    channel k word in bits [k*WIDTH +: WIDTH]
//   out_valid   bit k set while channel k holds an unconsumed word
//   out_ready   bit k set when channel k's consumer takes its word
//   ptr         accept counter modulo 4
//   frame_done  one-cycle pulse after every 4th accepted word
// ---------------------------------------------------------------------------
module demux_1_4_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef DEMUX_EXPLICIT_SEL_EN
    input  logic [1:0]         s,
`endif
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         ptr,
    output logic               frame_done
);

    logic [WIDTH-1:0] data_p1 [4];
    logic [3:0]       vld_p1;
    logic [1:0]       ptr_p1;
    logic             frame_done_p1;

    logic [1:0]       tgt;
    logic             accept;

`ifdef DEMUX_EXPLICIT_SEL_EN
    assign tgt = s;
`else
    assign tgt = ptr_p1;
`endif

    // A full target stalls the whole stream; there is no skipping ahead to a
    // free channel. A word leaving the target on this edge frees its slot.
    assign in_ready = ~vld_p1[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready;

    // ---- stage p1: channel registers, accept counter, frame pulse ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                data_p1[k] <= '0;
            end
            vld_p1        <= 4'b0000;
            ptr_p1        <= 2'd0;
            frame_done_p1 <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (tgt == 2'(k))) begin
                    // Load wins over drain: a consume and a refill on the
                    // same edge leave the channel valid with the new word.
                    data_p1[k] <= in_data;
                    vld_p1[k]  <= 1'b1;
                end else if (vld_p1[k] && out_ready[k]) begin
                    vld_p1[k]  <= 1'b0;
                end
            end
            if (accept) begin
                ptr_p1 <= ptr_p1 + 2'd1;
            end
            frame_done_p1 <= accept && (ptr_p1 == 2'd3);
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_p1[k];
        end
    end

    assign out_valid  = vld_p1;
    assign ptr        = ptr_p1;
    assign frame_done = frame_done_p1;

endmodule
